// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types and helpers for the bitwise shift controller
//
// Purpose : function/route codes, controller states, default register width
//           and the one-bit function evaluator used by bit_compute.
// Ports   : none (package).
package calc_pkg;

  localparam int CALC_WIDTH = 8;

  typedef enum logic [2:0] {
    FN_AND  = 3'b000,
    FN_OR   = 3'b001,
    FN_XOR  = 3'b010,
    FN_ONE  = 3'b011,
    FN_NAND = 3'b100,
    FN_NOR  = 3'b101,
    FN_XNOR = 3'b110,
    FN_ZERO = 3'b111
  } calc_func_e;

  typedef enum logic [1:0] {
    RT_KEEP = 2'b00,  // A<-A, B<-B
    RT_B_F  = 2'b01,  // A<-A, B<-f
    RT_A_F  = 2'b10,  // A<-f, B<-B
    RT_SWAP = 2'b11   // A<-B, B<-A
  } calc_route_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    HOLD  = 2'b10
  } ctrl_state_e;

  function automatic logic calc_f(input calc_func_e fn, input logic a, input logic b);
    logic r;
    case (fn)
      FN_AND:  r = a & b;
      FN_OR:   r = a | b;
      FN_XOR:  r = a ^ b;
      FN_ONE:  r = 1'b1;
      FN_NAND: r = ~(a & b);
      FN_NOR:  r = ~(a | b);
      FN_XNOR: r = ~(a ^ b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bit_compute.sv
// rtl/bit_compute.sv - combinational serial-in bit generator
//
// Purpose : evaluates f = F(A_out,B_out) and routes it (or the shifted-out
//           bits) to the serial inputs of the A and B registers.
// Ports   : i_func   latched function code
//           i_route  latched routing code
//           i_a_out  bit shifted out of A
//           i_b_out  bit shifted out of B
//           o_a_in   serial-in bit for A
//           o_b_in   serial-in bit for B
module bit_compute
  import calc_pkg::*;
(
  input  calc_func_e  i_func,
  input  calc_route_e i_route,
  input  logic        i_a_out,
  input  logic        i_b_out,
  output logic        o_a_in,
  output logic        o_b_in
);

  logic w_f;

  assign w_f = calc_f(i_func, i_a_out, i_b_out);

  always_comb begin
    o_a_in = i_a_out;
    o_b_in = i_b_out;
    case (i_route)
      RT_KEEP: begin o_a_in = i_a_out; o_b_in = i_b_out; end
      RT_B_F:  begin o_a_in = i_a_out; o_b_in = w_f;     end
      RT_A_F:  begin o_a_in = w_f;     o_b_in = i_b_out; end
      default: begin o_a_in = i_b_out; o_b_in = i_a_out; end
    endcase
  end

endmodule

// File: rtl/bitwise_shift_ctrl.sv
// rtl/bitwise_shift_ctrl.sv - control/compute stage for two serial shift registers
//
// Purpose : turns Execute/LoadA/LoadB levels into Ld_A, Ld_B and Shift_En
//           strobes, runs WIDTH shifts per Execute, and supplies serial-in
//           bits through bit_compute.
// Config  : BITWISE_SHIFT_CTRL_SYNC_EN - when defined, Execute/LoadA/LoadB
//           pass a 2-flop synchronizer before edge detection (+2 cycles).
// Ports   : Clk, Reset (async, active-low)
//           Execute, LoadA, LoadB  level inputs
//           F[2:0], R[1:0]         function / route codes (latched at start)
//           A_out, B_out           bits shifted out of A / B
//           Ld_A, Ld_B, Shift_En   register strobes
//           A_In, B_In             serial-in bits
//           Busy (SHIFT), Done (HOLD)
module bitwise_shift_ctrl
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Execute,
  input  logic       LoadA,
  input  logic       LoadB,
  input  logic [2:0] F,
  input  logic [1:0] R,
  input  logic       A_out,
  input  logic       B_out,
  output logic       Ld_A,
  output logic       Ld_B,
  output logic       Shift_En,
  output logic       A_In,
  output logic       B_In,
  output logic       Busy,
  output logic       Done
);

  // Bit order of the level bundle: [2]=Execute, [1]=LoadB, [0]=LoadA
  logic [2:0]  w_in;
  logic [2:0]  w_rise;
  logic [2:0]  r_in_q;

`ifdef BITWISE_SHIFT_CTRL_SYNC_EN
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {Execute, LoadB, LoadA};
      r_sync2 <= r_sync1;
    end
  end

  assign w_in = r_sync2;
`else
  assign w_in = {Execute, LoadB, LoadA};
`endif

  // Previous-level flops update in every state, so a level held across
  // SHIFT/HOLD produces no edge once the controller is back in IDLE.
  assign w_rise = w_in & ~r_in_q;

  ctrl_state_e        r_state;
  logic [CNT_W-1:0]   r_cnt;
  calc_func_e         r_func;
  calc_route_e        r_route;
  logic               r_ld_a;
  logic               r_ld_b;
  logic               r_shift_en;
  logic               r_busy;
  logic               r_done;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_func     <= FN_AND;
      r_route    <= RT_KEEP;
      r_in_q     <= '0;
      r_ld_a     <= 1'b0;
      r_ld_b     <= 1'b0;
      r_shift_en <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_in_q <= w_in;
      r_ld_a <= 1'b0;
      r_ld_b <= 1'b0;
      case (r_state)
        IDLE: begin
          // Execute has priority: a simultaneous load edge is dropped.
          if (w_rise[2]) begin
            r_state    <= SHIFT;
            r_cnt      <= '0;
            r_func     <= calc_func_e'(F);
            r_route    <= calc_route_e'(R);
            r_shift_en <= 1'b1;
            r_busy     <= 1'b1;
          end else begin
            r_ld_a <= w_rise[0];
            r_ld_b <= w_rise[1];
          end
        end
        SHIFT: begin
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_state    <= HOLD;
            r_shift_en <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (!w_in[2]) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_shift_en <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  assign Ld_A     = r_ld_a;
  assign Ld_B     = r_ld_b;
  assign Shift_En = r_shift_en;
  assign Busy     = r_busy;
  assign Done     = r_done;

  bit_compute u_bit_compute (
    .i_func  (r_func),
    .i_route (r_route),
    .i_a_out (A_out),
    .i_b_out (B_out),
    .o_a_in  (A_In),
    .o_b_in  (B_In)
  );

endmodule

// File: tb/tb_bitwise_shift_ctrl.sv
// tb/tb_bitwise_shift_ctrl.sv - scoreboard bench for bitwise_shift_ctrl
module tb_bitwise_shift_ctrl;

`ifdef BITWISE_SHIFT_CTRL_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Execute;
  logic       LoadA;
  logic       LoadB;
  logic [2:0] F;
  logic [1:0] R;
  logic       A_out;
  logic       B_out;
  logic       Ld_A;
  logic       Ld_B;
  logic       Shift_En;
  logic       A_In;
  logic       B_In;
  logic       Busy;
  logic       Done;

  logic [7:0] a_reg = 8'h01;
  logic [7:0] b_reg = 8'h00;
  logic [7:0] a_par = 8'h00;
  logic [7:0] b_par = 8'h00;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
  } exp_t;

  exp_t sb[$];

  bitwise_shift_ctrl dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Execute  (Execute),
    .LoadA    (LoadA),
    .LoadB    (LoadB),
    .F        (F),
    .R        (R),
    .A_out    (A_out),
    .B_out    (B_out),
    .Ld_A     (Ld_A),
    .Ld_B     (Ld_B),
    .Shift_En (Shift_En),
    .A_In     (A_In),
    .B_In     (B_In),
    .Busy     (Busy),
    .Done     (Done)
  );

  always #5 Clk = ~Clk;

  // The two external shift registers driven by the controller
  assign A_out = a_reg[0];
  assign B_out = b_reg[0];

  always @(posedge Clk) begin
    if (Ld_A) a_reg <= a_par;
    else if (Shift_En) a_reg <= {A_In, a_reg[7:1]};
    if (Ld_B) b_reg <= b_par;
    else if (Shift_En) b_reg <= {B_In, b_reg[7:1]};
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Monitor: every Done rising edge completes one operation
  initial begin
    int   cnt;
    logic done_q;
    exp_t e;
    cnt    = 0;
    done_q = 1'b0;
    forever begin
      @(negedge Clk);
      if (!Reset) begin
        cnt    = 0;
        done_q = 1'b0;
      end else begin
        if (Shift_En) cnt++;
        if (Done && !done_q) begin
          if (sb.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check({e.name, "_a"}, 32'(a_reg), 32'(e.a));
            check({e.name, "_b"}, 32'(b_reg), 32'(e.b));
            check({e.name, "_shifts"}, 32'(cnt), 32'd8);
          end
          cnt = 0;
        end
        done_q = Done;
      end
    end
  end

  task automatic load_regs(input logic [7:0] a, input logic [7:0] b);
    a_par = a;
    b_par = b;
    LoadA = 1'b1;
    LoadB = 1'b1;
    tick(LAT);
    check("load_both", 32'({Ld_A, Ld_B}), 32'b11);
    LoadA = 1'b0;
    LoadB = 1'b0;
    tick(3);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 50; k++) begin
      tick(1);
      if (!Busy && !Done) break;
    end
    check("idle_timeout", 32'({Busy, Done}), 32'd0);
  endtask

  // mode: 0 plain, 1 LoadB pressed mid-shift, 2 LoadA with Execute, 3 F changed mid-shift
  task automatic run_op(input string nm, input logic [2:0] f, input logic [1:0] r,
                        input logic [7:0] ea, input logic [7:0] eb,
                        input int hold, input int mode);
    int sh;
    int lds;
    exp_t e;
    e.name = nm;
    e.a    = ea;
    e.b    = eb;
    sb.push_back(e);
    F       = f;
    R       = r;
    Execute = 1'b1;
    if (mode == 2) LoadA = 1'b1;
    tick(LAT);
    check({nm, "_start"}, 32'({Shift_En, Busy}), 32'b11);
    sh  = 1;
    lds = 0;
    for (int i = 0; i < hold; i++) begin
      if (mode == 1 && i == 2) LoadB = 1'b1;
      if (mode == 1 && i == 4) LoadB = 1'b0;
      if (mode == 2 && i == 4) LoadA = 1'b0;
      if (mode == 3 && i == 3) F = 3'b000;
      tick(1);
      if (Shift_En) sh++;
      if (Ld_A || Ld_B) lds++;
    end
    check({nm, "_done_held"}, 32'(Done), 32'd1);
    check({nm, "_shift_total"}, 32'(sh), 32'd8);
    check({nm, "_no_loads"}, 32'(lds), 32'd0);
    Execute = 1'b0;
    wait_idle();
    tick(1);
  endtask

  initial begin
    int cnt;
    Reset   = 1'b0;
    Execute = 1'b0;
    LoadA   = 1'b0;
    LoadB   = 1'b0;
    F       = 3'b000;
    R       = 2'b00;
    tick(2);
    check("reset_strobes", 32'({Ld_A, Ld_B, Shift_En, Busy, Done}), 32'd0);
    check("reset_serial", 32'({A_In, B_In}), 32'b10);
    Reset = 1'b1;
    tick(2);

    // AND routed into A
    load_regs(8'h33, 8'h55);
    run_op("and_to_a", 3'b000, 2'b10, 8'h11, 8'h55, 20, 0);

    // swap, function ignored
    load_regs(8'h33, 8'h55);
    run_op("swap", 3'b101, 2'b11, 8'h55, 8'h33, 20, 0);

    // constant ONE routed into B
    load_regs(8'h0F, 8'h00);
    run_op("one_to_b", 3'b011, 2'b01, 8'h0F, 8'hFF, 20, 0);

    // LoadA held: exactly one pulse
    a_par = 8'hA5;
    LoadA = 1'b1;
    cnt   = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 10) LoadA = 1'b0;
      tick(1);
      if (Ld_A) cnt++;
    end
    check("loada_held_pulses", 32'(cnt), 32'd1);
    check("loada_held_value", 32'(a_reg), 32'hA5);
    tick(2);

    // LoadB during SHIFT ignored; rotate leaves values intact
    load_regs(8'h33, 8'h55);
    b_par = 8'hEE;
    run_op("ldb_in_shift", 3'b000, 2'b00, 8'h33, 8'h55, 20, 1);

    // LoadA edge together with Execute is dropped
    a_par = 8'hEE;
    run_op("exec_wins", 3'b000, 2'b00, 8'h33, 8'h55, 20, 2);

    // Reset after the third shift abandons the operation
    load_regs(8'h33, 8'h55);
    F       = 3'b000;
    R       = 2'b00;
    Execute = 1'b1;
    tick(LAT);
    tick(3);
    Reset = 1'b0;
    #1;
    check("reset_mid_op", 32'({Shift_En, Busy, Done, Ld_A, Ld_B}), 32'd0);
    Execute = 1'b0;
    tick(2);
    Reset = 1'b1;
    tick(2);
    run_op("after_reset", 3'b000, 2'b00, 8'h66, 8'hAA, 20, 0);

    // F changed mid-shift, Execute held long: latched XOR used, no retrigger
    load_regs(8'h33, 8'h55);
    run_op("latched_f", 3'b010, 2'b10, 8'h66, 8'h55, 30, 3);

    for (int k = 0; k < 100; k++) begin
      if (sb.size() == 0) break;
      tick(1);
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
